// File: rtl/nios2_div_pkg.sv
// nios2_div_pkg: shared types and constants for the Nios II iterative divider
package nios2_div_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV_ZERO_QUOT = '1;

    function automatic int clog2(input int n);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/nios2_div_step.sv
// nios2_div_step: one restoring-division step (shift in dividend bit, trial subtract)
module nios2_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             qbit
);
    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] diff;
    assign sh      = {rem, dvd_msb};
    assign diff    = {1'b0, sh} - {2'b00, dvs};
    assign qbit    = ~diff[WIDTH+1];
    assign rem_nxt = WIDTH'(qbit ? diff : {1'b0, sh});
endmodule

// File: rtl/nios2_cpu_div_cell.sv
// nios2_cpu_div_cell: radix-2 restoring divider, signed/unsigned, busy/done handshake
// Optional early exit for trivial operands when NIOS2_DIV_FAST_PATH_EN is defined.
module nios2_cpu_div_cell
    import nios2_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E_div_start,
    input  logic             E_ctrl_div_signed,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    input  logic             M_div_kill,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quot,
    output logic [WIDTH-1:0] M_div_rem
);
    localparam int CW = clog2(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a, b, dvd, dvs, p_rem, rem_nxt, mag1, mag2, q_fix, r_fix;
    logic             sgn, qs, rs, qbit, dz, ovf;
`ifdef NIOS2_DIV_FAST_PATH_EN
    logic             triv, fast;
    assign fast = dz || ovf || (mag1 < mag2);
`endif

    assign M_div_busy = (state != IDLE);
    assign M_div_done = (state == DONE);
    assign mag1 = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag2 = (sgn && b[WIDTH-1]) ? -b : b;
    assign dz   = (b == '0);
    assign ovf  = sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    nios2_div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (p_rem),
        .dvd_msb (dvd[WIDTH-1]),
        .dvs     (dvs),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    // Special cases override the iterated result; divide-by-zero has the last word.
    always_comb begin
        q_fix = qs ? -dvd : dvd;
        r_fix = rs ? -p_rem : p_rem;
`ifdef NIOS2_DIV_FAST_PATH_EN
        if (triv) begin
            q_fix = '0;
            r_fix = a;
        end
`endif
        if (ovf) begin
            q_fix = a;
            r_fix = '0;
        end
        if (dz) begin
            q_fix = '1;
            r_fix = a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            M_div_quot <= '0;
            M_div_rem  <= '0;
            a          <= '0;
            b          <= '0;
            sgn        <= 1'b0;
            dvd        <= '0;
            dvs        <= '0;
            p_rem      <= '0;
            qs         <= 1'b0;
            rs         <= 1'b0;
`ifdef NIOS2_DIV_FAST_PATH_EN
            triv       <= 1'b0;
`endif
        end else if (M_div_kill && state != IDLE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (E_div_start && !M_div_kill) begin
                    a     <= E_src1;
                    b     <= E_src2;
                    sgn   <= E_ctrl_div_signed;
                    state <= PREP;
                end
                PREP: begin
                    dvd   <= mag1;
                    dvs   <= mag2;
                    p_rem <= '0;
                    qs    <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                    rs    <= sgn && a[WIDTH-1];
`ifdef NIOS2_DIV_FAST_PATH_EN
                    triv  <= fast;
                    cnt   <= fast ? '0 : CW'(WIDTH - 1);
`else
                    cnt   <= CW'(WIDTH - 1);
`endif
                    state <= ITER;
                end
                ITER: begin
                    p_rem <= rem_nxt;
                    dvd   <= {dvd[WIDTH-2:0], qbit};
                    cnt   <= cnt - 1'b1;
                    state <= (cnt == '0) ? FIX : ITER;
                end
                FIX: begin
                    M_div_quot <= q_fix;
                    M_div_rem  <= r_fix;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nios2_cpu_div_cell.sv
// tb_nios2_cpu_div_cell: randomized scoreboard bench for nios2_cpu_div_cell
// Expected quotient/remainder come from plain truncating-division arithmetic.
module tb_nios2_cpu_div_cell;
    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

`ifdef NIOS2_DIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        E_div_start = 1'b0;
    logic        E_ctrl_div_signed = 1'b0;
    logic [31:0] E_src1 = '0;
    logic [31:0] E_src2 = '0;
    logic        M_div_kill = 1'b0;
    logic        M_div_busy, M_div_done;
    logic [31:0] M_div_quot, M_div_rem;

    res_t exp_q[$];
    res_t mon_e;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    nios2_cpu_div_cell #(.WIDTH(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .E_div_start       (E_div_start),
        .E_ctrl_div_signed (E_ctrl_div_signed),
        .E_src1            (E_src1),
        .E_src2            (E_src2),
        .M_div_kill        (M_div_kill),
        .M_div_busy        (M_div_busy),
        .M_div_done        (M_div_done),
        .M_div_quot        (M_div_quot),
        .M_div_rem         (M_div_rem)
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic res_t model(input logic s, input logic [31:0] x, input logic [31:0] y);
        res_t r;
        if (y == 0) begin
            r.q = 32'hFFFF_FFFF;
            r.r = x;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            r.q = x;
            r.r = 0;
        end else if (s) begin
            r.q = $signed(x) / $signed(y);
            r.r = $signed(x) % $signed(y);
        end else begin
            r.q = x / y;
            r.r = x % y;
        end
        return r;
    endfunction

    function automatic int lat_of(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] mx, my;
        logic        triv;
        mx = (s && x[31]) ? -x : x;
        my = (s && y[31]) ? -y : y;
        triv = (y == 0) || (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) || (mx < my);
        return (FAST && triv) ? 4 : 35;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
        E_ctrl_div_signed = s;
        E_src1 = x;
        E_src2 = y;
        E_div_start = 1'b1;
        tick();
        E_div_start = 1'b0;
    endtask

    // Entered in cycle T+t0 of an operation whose start was sampled in cycle T.
    task automatic wait_done(input int t0, input int exp_lat, input string n);
        int lat = t0;
        int bc = t0 - 1;
        while (!M_div_done && lat < 200) begin
            bc += int'(M_div_busy);
            tick();
            lat++;
        end
        bc += int'(M_div_busy);
        chk({n, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({n, "_busy"}, 64'(bc), 64'(exp_lat));
        tick();
        chk({n, "_idle"}, 64'(M_div_busy), 64'd0);
    endtask

    task automatic run_op(input logic s, input logic [31:0] x, input logic [31:0] y, input string n);
        exp_q.push_back(model(s, x, y));
        issue(s, x, y);
        wait_done(1, lat_of(s, x, y), n);
    endtask

    always @(negedge clk) begin
        if (M_div_done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 64'(M_div_done), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("quot", 64'(M_div_quot), 64'(mon_e.q));
                chk("rem", 64'(M_div_rem), 64'(mon_e.r));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t        e;
        logic [31:0] x, y;
        logic        s;
        int          lat;
        repeat (2) tick();
        chk("rst_busy", 64'(M_div_busy), 64'd0);
        chk("rst_done", 64'(M_div_done), 64'd0);
        chk("rst_quot", 64'(M_div_quot), 64'd0);
        chk("rst_rem", 64'(M_div_rem), 64'd0);
        reset = 1'b0;
        tick();

        run_op(1'b0, 32'd100, 32'd7, "u100_7");
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, "s_m100_7");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "u_big");
        run_op(1'b0, 32'h0000_1234, 32'd0, "u_dz");
        run_op(1'b1, 32'h0000_1234, 32'd0, "s_dz");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_ovf");

        // kill mid-operation: no done, outputs untouched
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) tick();
        M_div_kill = 1'b1;
        tick();
        M_div_kill = 1'b0;
        chk("kill_busy", 64'(M_div_busy), 64'd0);
        chk("kill_hold_quot", 64'(M_div_quot), 64'h8000_0000);
        tick();
        run_op(1'b0, 32'd9, 32'd2, "after_kill");

        // kill beats start in IDLE
        E_div_start = 1'b1;
        M_div_kill = 1'b1;
        tick();
        E_div_start = 1'b0;
        M_div_kill = 1'b0;
        chk("kill_start_busy", 64'(M_div_busy), 64'd0);

        // reset mid-operation
        issue(1'b1, -32'sd5000, 32'd77);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        chk("midrst_busy", 64'(M_div_busy), 64'd0);
        chk("midrst_done", 64'(M_div_done), 64'd0);
        chk("midrst_quot", 64'(M_div_quot), 64'd0);
        chk("midrst_rem", 64'(M_div_rem), 64'd0);
        reset = 1'b0;
        tick();

        // start held high: second op sampled in the IDLE cycle after done
        exp_q.push_back(model(1'b0, 32'd5000, 32'd13));
        E_ctrl_div_signed = 1'b0;
        E_src1 = 32'd5000;
        E_src2 = 32'd13;
        E_div_start = 1'b1;
        tick();
        E_src1 = 32'd1;
        E_src2 = 32'd1;
        lat = 1;
        while (!M_div_done && lat < 200) begin
            tick();
            lat++;
        end
        chk("b2b_lat1", 64'(lat), 64'(lat_of(1'b0, 32'd5000, 32'd13)));
        E_ctrl_div_signed = 1'b1;
        E_src1 = 32'd77777;
        E_src2 = 32'hFFFF_FFF6;
        exp_q.push_back(model(1'b1, 32'd77777, 32'hFFFF_FFF6));
        tick();
        chk("b2b_gap_busy", 64'(M_div_busy), 64'd0);
        tick();
        E_div_start = 1'b0;
        wait_done(1, lat_of(1'b1, 32'd77777, 32'hFFFF_FFF6), "b2b2");

        // start pulses while busy are ignored
        e = model(1'b1, -32'sd123456, 32'd789);
        exp_q.push_back(e);
        issue(1'b1, -32'sd123456, 32'd789);
        for (int i = 0; i < 3; i++) begin
            E_src1 = $urandom;
            E_src2 = $urandom_range(1, 50);
            E_div_start = 1'b1;
            tick();
            E_div_start = 1'b0;
            tick();
        end
        wait_done(7, 35, "ignore");
        repeat (40) tick();
        chk("ignore_hold_quot", 64'(M_div_quot), 64'(e.q));
        chk("ignore_hold_rem", 64'(M_div_rem), 64'(e.r));

        // randomized operands across sign modes and divisor shapes
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            x = (i % 5 == 2) ? 32'($urandom_range(0, 1000)) : $urandom;
            case (i % 5)
                0: y = $urandom;
                1: y = $urandom_range(1, 300);
                2: y = -32'($urandom_range(1, 300));
                3: y = x >> $urandom_range(1, 8);
                default: y = (i % 10 == 4) ? 32'd0 : 32'($urandom_range(1, 65535));
            endcase
            run_op(s, x, y, "rand");
        end

        repeat (5) tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
